parking_lot_multigate: RTL
==========================

# parking_lot_multigate

Parametrised multi-gate occupancy counter for the parking-lot system. Each of `GATES` entrances has an outer/inner photo-sensor pair. A per-gate direction FSM turns sensor sequences into single-cycle enter/exit events and ignores pedestrians and aborted passages. A shared saturating counter tracks occupancy up to `CAPACITY`. It sits between the GPIO sensor pins and the top-level HEX display decoder, which consumes `count`, `full` and `empty`.

## Interface
- `GATES`, 2, number of gate sensor pairs (1..8)
- `CAPACITY`, 16, maximum occupancy (1..255)
- `CNT_W`, `$clog2(CAPACITY+1)`, width of `count`
- `clk`  in  1  system clock (50 MHz)
- `reset`  in  1  asynchronous, active-low reset
- `outer`  in  GATES  outer sensor per gate, 1 = blocked, asynchronous to `clk`
- `inner`  in  GATES  inner sensor per gate, 1 = blocked, asynchronous to `clk`
- `enter_pulse`  out  GATES  one-cycle pulse per completed car entry
- `exit_pulse`  out  GATES  one-cycle pulse per completed car exit
- `count`  out  CNT_W  current occupancy
- `full`  out  1  `count == CAPACITY`
- `empty`  out  1  `count == 0`
- `err_over`  out  1  sticky: an entry was dropped because the lot was full
- `err_under`  out  1  sticky: an exit was dropped because the lot was empty

## Operation
- Synchronisation: each `outer`/`inner` bit passes through a 2-flop synchroniser. The FSM acts only on synchronised values `o`, `i`.
- Per-gate FSM states: IDLE, E1 (o only), E2 (o&i), E3 (i only), X1 (i only), X2 (o&i), X3 (o only), AMBIG.
- Entry path: IDLE→E1 on o&!i; E1→E2 on o&i; E2→E3 on !o&i; E3→IDLE on !o&!i, asserting `enter_pulse`.
- Exit path: mirrored with o and i swapped (IDLE→X1→X2→X3→IDLE), asserting `exit_pulse`.
- Backing out: moving back one step is legal (E2→E1, E3→E2, X2→X1, X3→X2).
  - E1→IDLE and X1→IDLE on both clear, with no event.
  - E3 or X3 sensor returning to o&i goes back to E2/X2.
- Pedestrian (one sensor blocked and cleared before the other): returns to IDLE with no event.
- Any other input combination, including IDLE seeing o&i, moves to AMBIG. AMBIG→IDLE only when both sensors are clear, with no event.
- Counter update each cycle: next = count + popcount(enter) − popcount(exit), computed signed over CNT_W+4 bits.
  - next > CAPACITY: clamp to CAPACITY and set `err_over`.
  - next < 0: clamp to 0 and set `err_under`.
  - Simultaneous enter and exit events on different gates net out before clamping. An enter and an exit in the same cycle while full gives no error.
- `full` and `empty` are combinational compares on the registered `count`.
- `err_over` and `err_under` clear only on reset.

## Timing
- Reset (`reset`=0, asynchronous): every FSM goes to IDLE, synchronisers clear to 0. `count`=0, `empty`=1, `full`=0, pulses=0, error flags=0.
- Release of reset is synchronised internally. The first FSM transition can occur on the 2nd `clk` edge after `reset` rises.
- Latency from the edge that first samples the final sensor change at the pin to the `enter_pulse`/`exit_pulse` high cycle: 3 cycles (2 synchroniser + 1 FSM register).
- `count`, `full`, `empty` and the error flags reflect an event 1 cycle after its pulse.
- Each pulse is exactly 1 cycle wide. A gate produces at most 1 event per passage.
- A gate's FSM can start a new passage in the cycle after its pulse.
- Reset asserted mid-passage abandons the passage: no pulse and no count change. After release, the gate sits in IDLE, or moves to AMBIG if a sensor is still blocked.

## Test plan
- Reset, then gate 0 entry (o, o&i, i, clear; each held 5 cycles) → `enter_pulse[0]` high 1 cycle exactly 3 cycles after clear is sampled; `count` 0→1 the next cycle; `empty` falls.
- `CAPACITY`=4: 5 entries on gate 1 → `count`=4, `full`=1, `err_over`=1 after the 5th. Then 1 exit → `count`=3, `full`=0, `err_over` stays 1.
- Pedestrian on gate 0 (o, clear, i, clear), and also o&i from IDLE → no pulses, `count` unchanged. AMBIG returns to IDLE, proven by a following valid entry that counts.
- Aborted entry (o, o&i, o, clear) → no pulse. Exit on an empty lot → `count`=0, `err_under`=1.
- `count`=2: gate 0 entry and gate 1 exit completing on the same cycle → both pulses high the same cycle, `count` stays 2, no error flags.
- Assert `reset` low during E2 with `count`=3 → `count`=0 immediately (asynchronous). After release with sensors clear, the FSM is in IDLE and no pulse is produced.

Source files
------------

// File: rtl/parking_lot_multigate.sv
// parking_lot_multigate
// Multi-gate parking-lot occupancy counter. Each gate has an outer/inner
// photo-sensor pair feeding a direction FSM that emits single-cycle
// enter/exit pulses. A shared saturating counter tracks occupancy and
// raises sticky over/under flags when events have to be dropped.

module parking_lot_multigate #(
    parameter int GATES    = 2,
    parameter int CAPACITY = 16,
    parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [GATES-1:0] outer,
    input  logic [GATES-1:0] inner,
    output logic [GATES-1:0] enter_pulse,
    output logic [GATES-1:0] exit_pulse,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             err_over,
    output logic             err_under
);

    // Signed working width: count plus the net of up to 8 simultaneous events.
    localparam int SUM_W = CNT_W + 4;
    localparam logic signed [SUM_W-1:0] CAP_S   = SUM_W'(CAPACITY);
    localparam logic        [CNT_W-1:0] CAP_CNT = CNT_W'(CAPACITY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_E1,     // entering: outer only
        S_E2,     // entering: both blocked
        S_E3,     // entering: inner only
        S_X1,     // exiting: inner only
        S_X2,     // exiting: both blocked
        S_X3,     // exiting: outer only
        S_AMBIG   // unknown sequence, wait for both sensors clear
    } state_t;

    logic [2:0]       r_rel;
    logic [GATES-1:0] r_o_meta;
    logic [GATES-1:0] r_o_sync;
    logic [GATES-1:0] r_i_meta;
    logic [GATES-1:0] r_i_sync;
    state_t           r_state [GATES];
    logic [GATES-1:0] r_enter;
    logic [GATES-1:0] r_exit;
    logic [CNT_W-1:0] r_count;
    logic             r_err_over;
    logic             r_err_under;

    logic             w_run;
    logic             w_first;
    logic [1:0]       w_oi [GATES];
    logic signed [SUM_W-1:0] w_sum;
    logic             w_neg;
    logic             w_over;
    logic [CNT_W-1:0] w_next;

    function automatic logic [3:0] popcnt(input logic [GATES-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < GATES; k++) begin
            n = n + 4'(v[k]);
        end
        return n;
    endfunction

    // Reset-release pipeline: the FSMs stay frozen on the edge that
    // first sees reset high, then run; r_rel[1] & !r_rel[2] marks the first
    // edge whose synchronised sensor values were sampled after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rel <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_rel <= {r_rel[1:0], 1'b1};
        end
    end

    assign w_run   = r_rel[0];
    assign w_first = r_rel[1] & ~r_rel[2];

    // Two-flop synchronisers for the asynchronous sensor pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_o_meta <= '0;
            r_o_sync <= '0;
            r_i_meta <= '0;
            r_i_sync <= '0;
        end else begin
            r_o_meta <= outer;
            r_o_sync <= r_o_meta;
            r_i_meta <= inner;
            r_i_sync <= r_i_meta;
        end
    end

    // Pack each gate's synchronised {outer, inner} pair for the FSM case.
    always_comb begin
        for (int g = 0; g < GATES; g++) begin
            w_oi[g] = {r_o_sync[g], r_i_sync[g]};
        end
    end

    // Per-gate direction FSMs with registered enter/exit pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the state array is only a handful of flops per gate, so
            // every element is reset explicitly rather than left undefined.
            for (int g = 0; g < GATES; g++) begin
                r_state[g] <= S_IDLE;
            end
            r_enter <= '0;
            r_exit  <= '0;
        end else begin
            r_enter <= '0;
            r_exit  <= '0;
            if (w_run) begin
                for (int g = 0; g < GATES; g++) begin
                    case (r_state[g])
                        S_IDLE: begin
                            if (w_first && (w_oi[g] != 2'b00)) begin
                                // A sensor blocked across reset: passage unknown.
                                r_state[g] <= S_AMBIG;
                            end else begin
                                case (w_oi[g])
                                    2'b00:   r_state[g] <= S_IDLE;
                                    2'b10:   r_state[g] <= S_E1;
                                    2'b01:   r_state[g] <= S_X1;
                                    default: r_state[g] <= S_AMBIG;
                                endcase
                            end
                        end
                        S_E1: begin
                            case (w_oi[g])
                                2'b10:   r_state[g] <= S_E1;
                                2'b11:   r_state[g] <= S_E2;
                                2'b00:   r_state[g] <= S_IDLE;
                                default: r_state[g] <= S_AMBIG;
                            endcase
                        end
                        S_E2: begin
                            case (w_oi[g])
                                2'b11:   r_state[g] <= S_E2;
                                2'b01:   r_state[g] <= S_E3;
                                2'b10:   r_state[g] <= S_E1;
                                default: r_state[g] <= S_AMBIG;
                            endcase
                        end
                        S_E3: begin
                            case (w_oi[g])
                                2'b01:   r_state[g] <= S_E3;
                                2'b11:   r_state[g] <= S_E2;
                                2'b00: begin
                                    r_state[g] <= S_IDLE;
                                    r_enter[g] <= 1'b1;
                                end
                                default: r_state[g] <= S_AMBIG;
                            endcase
                        end
                        S_X1: begin
                            case (w_oi[g])
                                2'b01:   r_state[g] <= S_X1;
                                2'b11:   r_state[g] <= S_X2;
                                2'b00:   r_state[g] <= S_IDLE;
                                default: r_state[g] <= S_AMBIG;
                            endcase
                        end
                        S_X2: begin
                            case (w_oi[g])
                                2'b11:   r_state[g] <= S_X2;
                                2'b10:   r_state[g] <= S_X3;
                                2'b01:   r_state[g] <= S_X1;
                                default: r_state[g] <= S_AMBIG;
                            endcase
                        end
                        S_X3: begin
                            case (w_oi[g])
                                2'b10:   r_state[g] <= S_X3;
                                2'b11:   r_state[g] <= S_X2;
                                2'b00: begin
                                    r_state[g] <= S_IDLE;
                                    r_exit[g]  <= 1'b1;
                                end
                                default: r_state[g] <= S_AMBIG;
                            endcase
                        end
                        default: begin
                            if (w_oi[g] == 2'b00) begin
                                r_state[g] <= S_IDLE;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // Net this cycle's events against the count, then clamp to 0..CAPACITY.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        w_sum  = SUM_W'(r_count) + SUM_W'(popcnt(r_enter)) - SUM_W'(popcnt(r_exit));
        w_neg  = w_sum[SUM_W-1];
        w_over = !w_neg && (w_sum > CAP_S);
        w_next = w_sum[CNT_W-1:0];
        if (w_over) begin
            w_next = CAP_CNT;
        end else if (w_neg) begin
            w_next = '0;
        end
    end

    // Occupancy register and sticky drop flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count     <= '0;
            r_err_over  <= 1'b0;
            r_err_under <= 1'b0;
        end else begin
            r_count <= w_next;
            if (w_over) begin
                r_err_over <= 1'b1;
            end
            if (w_neg) begin
                r_err_under <= 1'b1;
            end
        end
    end

    assign enter_pulse = r_enter;
    assign exit_pulse  = r_exit;
    assign count       = r_count;
    assign full        = (r_count == CAP_CNT);
    assign empty       = (r_count == '0);
    assign err_over    = r_err_over;
    assign err_under   = r_err_under;

endmodule
